fp_divider_seq: RTL
===================

Name: fp_divider_seq

Overview:
- Sequential IEEE-754 single-precision divider; the inverse-operation companion to the team's combinational FP32 multiplier.
- Flag semantics and flush policy match the multiplier:
  - Denormals are treated as zero.
  - Exception gives result 0.
  - Overflow saturates to signed infinity.
  - Underflow flushes to signed zero.
- Uses a radix-2 restoring mantissa divider, one quotient bit per cycle, with valid/ready handshakes on both sides. Sits in the FP datapath next to the multiplier.

Parameters:
- ROUND_EN, 1, 1 = round-to-nearest-even using guard/sticky; 0 = truncate.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block idle and able to accept.
- a_operand  input  32  dividend, FP32.
- b_operand  input  32  divisor, FP32.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts the result.
- result  output  32  quotient, FP32.
- Exception  output  1  an operand has exponent 255, or the operation is 0/0.
- Overflow  output  1  biased exponent >= 255.
- Underflow  output  1  biased exponent <= 0.
- DivByZero  output  1  nonzero finite dividend divided by zero.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=IDLE, in_ready=1, out_valid=0, result=0, all flags=0.
  - Any division in progress is aborted with no output. This also applies to a reset mid-DIV or while in DONE.
- States: IDLE, DIV, ROUND, DONE. in_ready=1 only in IDLE.
- IDLE:
  - On in_valid&in_ready, capture sign=a[31]^b[31], ea, eb, ma={|ea,a[22:0]}, mb={|eb,b[22:0]}.
  - Operand with exp 0 counts as zero.
  - Special-case classification at capture, in priority order; each goes directly to DONE:
    1. ea==255 or eb==255 -> result 0, Exception=1.
    2. Both zero -> result 0, Exception=1.
    3. b zero -> result {sign,8'hFF,23'd0}, DivByZero=1.
    4. a zero -> result {sign,31'd0}, no flags.
  - Otherwise go to DIV with rem=ma, cnt=0.
- DIV, 26 cycles:
  - Each cycle: if rem>=mb then q bit=1 and rem-=mb, else q bit=0; then rem<<=1.
  - Bits fill q[25] down to q[0]. rem is 25 bits wide.
  - After cnt==25, go to ROUND.
- ROUND, 1 cycle:
  - If q[25]=1: mant=q[24:2], guard=q[1], sticky=q[0]|(rem!=0), exp=ea-eb+127.
  - Else: mant=q[23:1], guard=q[0], sticky=(rem!=0), exp=ea-eb+126.
  - Exponent arithmetic is signed 10-bit.
  - round_up=ROUND_EN & guard & (sticky | mant[0]).
  - If mant==all-ones and round_up: mant=0, exp+=1.
  - If exp>=255 -> result {sign,8'hFF,0}, Overflow=1.
  - Else if exp<=0 -> result {sign,31'd0}, Underflow=1.
  - Else result {sign,exp[7:0],mant}.
  - Go to DONE.
- DONE:
  - out_valid=1; result and flags registered and held stable until out_ready.
  - On out_valid&out_ready, go to IDLE; out_valid drops the next cycle.
  - in_valid is ignored outside IDLE. There is no same-cycle accept on the DONE->IDLE transition.
- Latency, counted from the accept edge:
  - Normal path: out_valid rises after edge +28 (26 DIV + 1 ROUND + entry).
  - Special case: out_valid rises after edge +1.
  - Throughput is one operation per 29 cycles minimum.
- Flags are mutually exclusive and valid only while out_valid=1. They are cleared on leaving DONE.

Test Plan:
- 0x40C00000 / 0x40000000 (6/2) -> result 0x40400000, no flags, out_valid exactly 28 cycles after accept.
- 0x3F800000 / 0x40400000 (1/3) -> result 0x3EAAAAAB with ROUND_EN=1; 0x3EAAAAAA with ROUND_EN=0.
- Special cases, each with out_valid one cycle after accept:
  - 0x3F800000 / 0x00000000 -> 0x7F800000, DivByZero=1.
  - 0x00000000 / 0x00000000 -> 0x00000000, Exception=1.
  - 0x7FC00000 / 0x3F800000 -> 0x00000000, Exception=1.
- Overflow/underflow:
  - 0x7F7FFFFF / 0x3F000000 -> 0x7F800000, Overflow=1.
  - 0x80800000 / 0x40000000 -> 0x80000000, Underflow=1.
- Handshake and reset:
  - Hold out_ready=0 for 10 cycles in DONE -> result/flags stable, in_ready=0, new in_valid pulses ignored.
  - Assert rst_n=0 at DIV cycle 12 -> next cycle in_ready=1, out_valid=0, and no result is ever produced for that operation.

Source files
------------

// File: rtl/fp_divider_seq.sv
// Sequential FP32 divider: radix-2 restoring mantissa division, one quotient
// bit per cycle, followed by a single normalise/round cycle. Denormals are
// read as zero, overflow saturates to signed infinity, underflow flushes to
// signed zero, and any exception returns +0.
module fp_divider_seq #(
    parameter bit ROUND_EN = 1'b1   // 1: round-to-nearest-even, 0: truncate
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a_operand,
    input  logic [31:0] b_operand,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        Exception,
    output logic        Overflow,
    output logic        Underflow,
    output logic        DivByZero
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DIV   = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    // Captured operand fields and divider working registers
    logic        r_sign;
    logic [7:0]  r_ea;
    logic [7:0]  r_eb;
    logic [23:0] r_mb;
    logic [24:0] r_rem;
    logic [25:0] r_q;
    logic [4:0]  r_cnt;

    // Registered result and flags, held for the consumer while in DONE
    logic [31:0] r_result;
    logic        r_exception;
    logic        r_overflow;
    logic        r_underflow;
    logic        r_div_by_zero;

    // Operand classification at the input port
    logic [7:0]  w_ea;
    logic [7:0]  w_eb;
    logic        w_sign;
    logic        w_a_zero;
    logic        w_b_zero;
    logic        w_a_special_exp;
    logic        w_b_special_exp;
    logic        w_is_special;
    logic        w_accept;

    assign w_ea            = a_operand[30:23];
    assign w_eb            = b_operand[30:23];
    assign w_sign          = a_operand[31] ^ b_operand[31];
    assign w_a_zero        = (w_ea == 8'd0);
    assign w_b_zero        = (w_eb == 8'd0);
    assign w_a_special_exp = (w_ea == 8'hFF);
    assign w_b_special_exp = (w_eb == 8'hFF);
    assign w_is_special    = w_a_special_exp | w_b_special_exp | w_a_zero | w_b_zero;
    assign w_accept        = in_valid & (r_state == S_IDLE);

    // Restoring step. The partial remainder is always below 2*mb, so
    // rem - mb lies in (-2^24, 2^24): bit 24 of the 25-bit difference is
    // exactly the borrow, and its absence means rem >= mb.
    logic [24:0] w_sub;
    logic        w_ge;
    logic [24:0] w_rem_next;

    assign w_sub      = r_rem - {1'b0, r_mb};
    assign w_ge       = ~w_sub[24];
    assign w_rem_next = w_ge ? {w_sub[23:0], 1'b0} : {r_rem[23:0], 1'b0};

    // Normalisation and rounding of the finished quotient
    logic [22:0]       w_mant_sel;
    logic              w_guard;
    logic              w_sticky;
    logic              w_round_up;
    logic              w_mant_carry;
    logic [22:0]       w_mant_fin;
    logic signed [9:0] w_exp_base;
    logic signed [9:0] w_exp_fin;

    assign w_mant_sel   = r_q[25] ? r_q[24:2] : r_q[23:1];
    assign w_guard      = r_q[25] ? r_q[1] : r_q[0];
    assign w_sticky     = (r_q[25] & r_q[0]) | (r_rem != 25'd0);
    assign w_round_up   = ROUND_EN & w_guard & (w_sticky | w_mant_sel[0]);
    assign w_mant_carry = w_round_up & (&w_mant_sel);
    assign w_mant_fin   = w_round_up ? (w_mant_sel + 23'd1) : w_mant_sel;
    assign w_exp_base   = $signed({2'b00, r_ea}) - $signed({2'b00, r_eb})
                        + (r_q[25] ? 10'sd127 : 10'sd126);
    assign w_exp_fin    = w_exp_base + (w_mant_carry ? 10'sd1 : 10'sd0);

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: specials skip straight to DONE
    always_comb begin
        // NOTE: default assigned first so no path leaves w_state_next
        // unassigned, which would otherwise infer a latch.
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)          w_state_next = w_is_special ? S_DONE : S_DIV;
            S_DIV:   if (r_cnt == 5'd25)    w_state_next = S_ROUND;
            S_ROUND:                        w_state_next = S_DONE;
            S_DONE:  if (out_ready)         w_state_next = S_IDLE;
            default:                        w_state_next = S_IDLE;
        endcase
    end

    // Datapath: operand capture, divide steps, rounding and result hold
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sign        <= 1'b0;
            r_ea          <= 8'd0;
            r_eb          <= 8'd0;
            r_mb          <= 24'd0;
            r_rem         <= 25'd0;
            r_q           <= 26'd0;
            r_cnt         <= 5'd0;
            r_result      <= 32'd0;
            r_exception   <= 1'b0;
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
            r_div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sign <= w_sign;
                        r_ea   <= w_ea;
                        r_eb   <= w_eb;
                        r_mb   <= {~w_b_zero, b_operand[22:0]};
                        r_rem  <= {1'b0, ~w_a_zero, a_operand[22:0]};
                        r_q    <= 26'd0;
                        r_cnt  <= 5'd0;
                        if (w_a_special_exp || w_b_special_exp) begin
                            r_result    <= 32'd0;
                            r_exception <= 1'b1;
                        end else if (w_a_zero && w_b_zero) begin
                            r_result    <= 32'd0;
                            r_exception <= 1'b1;
                        end else if (w_b_zero) begin
                            r_result      <= {w_sign, 8'hFF, 23'd0};
                            r_div_by_zero <= 1'b1;
                        end else if (w_a_zero) begin
                            r_result <= {w_sign, 31'd0};
                        end
                    end
                end
                S_DIV: begin
                    r_q   <= {r_q[24:0], w_ge};
                    r_rem <= w_rem_next;
                    r_cnt <= r_cnt + 5'd1;
                end
                S_ROUND: begin
                    if (w_exp_fin >= 10'sd255) begin
                        r_result   <= {r_sign, 8'hFF, 23'd0};
                        r_overflow <= 1'b1;
                    end else if (w_exp_fin <= 10'sd0) begin
                        r_result    <= {r_sign, 31'd0};
                        r_underflow <= 1'b1;
                    end else begin
                        r_result <= {r_sign, w_exp_fin[7:0], w_mant_fin};
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_result      <= 32'd0;
                        r_exception   <= 1'b0;
                        r_overflow    <= 1'b0;
                        r_underflow   <= 1'b0;
                        r_div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;
    assign Exception = r_exception;
    assign Overflow  = r_overflow;
    assign Underflow = r_underflow;
    assign DivByZero = r_div_by_zero;

endmodule
